// File: rtl/sram_burst_controller.sv
// SRAM-side burst engine between the AXI request/response FIFOs and a
// single-port synchronous SRAM. It arbitrates reads and writes round-robin
// and runs INCR bursts of 1..2^LEN_WIDTH beats. Reads are pipelined through
// a return buffer that absorbs R FIFO backpressure. Beats to out-of-range
// addresses never touch the SRAM and complete with SLVERR.
//
// Handshake semantics: a FIFO pop (ren) or push (wen) takes effect at the
// rising edge that ends a cycle in which the strobe is high. Strobes are
// asserted only while the FIFO reports non-empty (pops) or not-full (pushes).
// For that reason the strobes are decoded from registered state and the
// current empty/full flags, not registered themselves.
module sram_burst_controller #(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int SRAM_ADDR_WIDTH = 16,
    parameter int SRAM_DATA_WIDTH = 32,
    parameter int READ_LATENCY    = 1,
    parameter int LEN_WIDTH       = 4
) (
    input  logic                                  sram_clk,
    input  logic                                  sram_rst,
    output logic [SRAM_ADDR_WIDTH-1:0]            sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0]            sram_din,
    input  logic [SRAM_DATA_WIDTH-1:0]            sram_dout,
    output logic [SRAM_DATA_WIDTH/8-1:0]          sram_we,
    output logic                                  sram_en,
    input  logic [LEN_WIDTH+AXI_ADDR_WIDTH-1:0]   aw_fifo_rdata,
    output logic                                  aw_fifo_ren,
    input  logic                                  aw_fifo_empty,
    input  logic [SRAM_DATA_WIDTH+SRAM_DATA_WIDTH/8-1:0] w_fifo_rdata,
    output logic                                  w_fifo_ren,
    input  logic                                  w_fifo_empty,
    input  logic [LEN_WIDTH+AXI_ADDR_WIDTH-1:0]   ar_fifo_rdata,
    output logic                                  ar_fifo_ren,
    input  logic                                  ar_fifo_empty,
    output logic [SRAM_DATA_WIDTH+2:0]            r_fifo_wdata,
    output logic                                  r_fifo_wen,
    input  logic                                  r_fifo_full,
    output logic [1:0]                            b_fifo_wdata,
    output logic                                  b_fifo_wen,
    input  logic                                  b_fifo_full
);

    localparam int BYTES  = SRAM_DATA_WIDTH / 8;
    localparam int OFF    = $clog2(BYTES);
    localparam int HI_LSB = SRAM_ADDR_WIDTH + OFF;
    localparam int DEPTH  = READ_LATENCY + 1;
    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int EW     = SRAM_DATA_WIDTH + 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_DRAIN,
        WR_BEAT,
        WR_RESP
    } state_t;

    state_t                     state;
    logic [SRAM_ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]       beats_left;
    logic                       burst_err;
    logic                       rr_read_first;

    // Request and write-beat field split
    logic [LEN_WIDTH-1:0]       ar_len;
    logic [LEN_WIDTH-1:0]       aw_len;
    logic [AXI_ADDR_WIDTH-1:0]  ar_baddr;
    logic [AXI_ADDR_WIDTH-1:0]  aw_baddr;
    logic [BYTES-1:0]           wstrb;
    logic [SRAM_DATA_WIDTH-1:0] wdata;
    logic                       ar_oor;
    logic                       aw_oor;
    logic                       unused_addr_bits;

    assign {ar_len, ar_baddr} = ar_fifo_rdata;
    assign {aw_len, aw_baddr} = aw_fifo_rdata;
    assign {wstrb, wdata}     = w_fifo_rdata;
    assign ar_oor = |ar_baddr[AXI_ADDR_WIDTH-1:HI_LSB];
    assign aw_oor = |aw_baddr[AXI_ADDR_WIDTH-1:HI_LSB];
    // Byte-offset bits below the word address carry no meaning here.
    assign unused_addr_bits = ^{ar_baddr, aw_baddr};

    // Read pipeline: one valid bit and tag per cycle of SRAM latency
    logic [READ_LATENCY-1:0] pipe_v;
    logic [READ_LATENCY-1:0] pipe_last;
    logic [READ_LATENCY-1:0] pipe_err;

    // Return buffer
    logic [EW-1:0] rbuf_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] rbuf_count;
    logic [CW-1:0] inflight;
    logic [CW:0]   occ;
    logic          cap;
    logic [EW-1:0] cap_entry;

    logic active;
    logic rd_pend;
    logic wr_pend;
    logic grant_rd;
    logic grant_wr;
    logic rd_issue;
    logic wr_beat;
    logic r_push;
    logic is_last;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign active   = !sram_rst;
    assign rd_pend  = !ar_fifo_empty;
    assign wr_pend  = !aw_fifo_empty && !w_fifo_empty;
    assign grant_rd = active && (state == IDLE) && rd_pend && (!wr_pend || rr_read_first);
    assign grant_wr = active && (state == IDLE) && wr_pend && (!rd_pend || !rr_read_first);
    assign is_last  = (beats_left == '0);
    assign r_push   = active && (rbuf_count != '0) && !r_fifo_full;
    assign wr_beat  = active && (state == WR_BEAT) && !w_fifo_empty;

    // Count beats issued to the SRAM whose data has not yet reached the buffer
    always_comb begin
        inflight = '0;
        for (int k = 0; k < READ_LATENCY; k++) begin
            inflight = inflight + CW'(pipe_v[k]);
        end
    end

    // A beat leaving the buffer this cycle frees its slot for a new issue,
    // which keeps unthrottled reads at one beat per cycle.
    assign occ      = {1'b0, inflight} + {1'b0, rbuf_count} - (CW + 1)'(r_push);
    assign rd_issue = active && (state == RD_ISSUE) && (occ < (CW + 1)'(DEPTH));

    assign ar_fifo_ren  = grant_rd;
    assign aw_fifo_ren  = grant_wr;
    assign w_fifo_ren   = wr_beat;
    assign r_fifo_wen   = r_push;
    assign r_fifo_wdata = r_push ? rbuf_mem[rd_ptr] : '0;
    assign b_fifo_wen   = active && (state == WR_RESP) && !b_fifo_full;
    assign b_fifo_wdata = burst_err ? RESP_SLVERR : RESP_OKAY;

    // SRAM port drive; out-of-range beats leave the SRAM untouched
    always_comb begin
        sram_en   = 1'b0;
        sram_we   = '0;
        sram_addr = '0;
        sram_din  = '0;
        if (rd_issue && !burst_err) begin
            sram_en   = 1'b1;
            sram_addr = cur_addr;
        end
        if (wr_beat && !burst_err) begin
            sram_en   = 1'b1;
            sram_we   = wstrb;
            sram_addr = cur_addr;
            sram_din  = wdata;
        end
    end

    // Burst FSM: arbitration, address walk and beat counting
    always_ff @(posedge sram_clk) begin
        if (sram_rst) begin
            state         <= IDLE;
            cur_addr      <= '0;
            beats_left    <= '0;
            burst_err     <= 1'b0;
            rr_read_first <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_rd) begin
                        cur_addr      <= ar_baddr[OFF +: SRAM_ADDR_WIDTH];
                        beats_left    <= ar_len;
                        burst_err     <= ar_oor;
                        rr_read_first <= !rr_read_first;
                        state         <= RD_ISSUE;
                    end else if (grant_wr) begin
                        cur_addr      <= aw_baddr[OFF +: SRAM_ADDR_WIDTH];
                        beats_left    <= aw_len;
                        burst_err     <= aw_oor;
                        rr_read_first <= !rr_read_first;
                        state         <= WR_BEAT;
                    end
                end
                RD_ISSUE: begin
                    if (rd_issue) begin
                        if (is_last) begin
                            state <= RD_DRAIN;
                        end else begin
                            beats_left <= beats_left - 1'b1;
                            cur_addr   <= cur_addr + 1'b1;
                        end
                    end
                end
                RD_DRAIN: begin
                    if ((inflight == '0) && (rbuf_count == '0)) begin
                        state <= IDLE;
                    end
                end
                WR_BEAT: begin
                    if (wr_beat) begin
                        if (is_last) begin
                            state <= WR_RESP;
                        end else begin
                            beats_left <= beats_left - 1'b1;
                            cur_addr   <= cur_addr + 1'b1;
                        end
                    end
                end
                WR_RESP: begin
                    if (b_fifo_wen) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Valid bits track issued reads; cleared on reset so in-flight data is dropped
    always_ff @(posedge sram_clk) begin
        if (sram_rst) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= rd_issue;
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_v[k] <= pipe_v[k-1];
            end
        end
    end

    // Tags ride alongside the valid bits; only meaningful where valid is set
    always_ff @(posedge sram_clk) begin
        pipe_last[0] <= is_last;
        pipe_err[0]  <= burst_err;
        for (int k = 1; k < READ_LATENCY; k++) begin
            pipe_last[k] <= pipe_last[k-1];
            pipe_err[k]  <= pipe_err[k-1];
        end
    end

    assign cap       = pipe_v[READ_LATENCY-1];
    assign cap_entry = {pipe_last[READ_LATENCY-1],
                        pipe_err[READ_LATENCY-1] ? RESP_SLVERR : RESP_OKAY,
                        pipe_err[READ_LATENCY-1] ? {SRAM_DATA_WIDTH{1'b0}} : sram_dout};

    // Return buffer pointers and occupancy
    always_ff @(posedge sram_clk) begin
        if (sram_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rbuf_count <= '0;
        end else begin
            if (cap) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (r_push) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            rbuf_count <= rbuf_count + CW'(cap) - CW'(r_push);
        end
    end

    // Return buffer storage, written as each beat's data arrives
    always_ff @(posedge sram_clk) begin
        if (cap) begin
            rbuf_mem[wr_ptr] <= cap_entry;
        end
    end

endmodule

// File: tb/tb_sram_burst_controller.sv
// Bench for sram_burst_controller: FIFO and SRAM models, an expected-value
// scoreboard for SRAM accesses, R beats and B responses, plus directed bursts.
module tb_sram_burst_controller;

  localparam int AW  = 32;
  localparam int SAW = 16;
  localparam int DW  = 32;
  localparam int BY  = DW / 8;
  localparam int RL  = 3;
  localparam int LW  = 4;
  localparam int SW  = SAW + BY + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [SAW-1:0]     sram_addr;
  logic [DW-1:0]      sram_din;
  logic [DW-1:0]      sram_dout;
  logic [BY-1:0]      sram_we;
  logic               sram_en;
  logic [LW+AW-1:0]   aw_fifo_rdata = '0;
  logic               aw_fifo_ren;
  logic               aw_fifo_empty = 1'b1;
  logic [DW+BY-1:0]   w_fifo_rdata = '0;
  logic               w_fifo_ren;
  logic               w_fifo_empty = 1'b1;
  logic [LW+AW-1:0]   ar_fifo_rdata = '0;
  logic               ar_fifo_ren;
  logic               ar_fifo_empty = 1'b1;
  logic [DW+2:0]      r_fifo_wdata;
  logic               r_fifo_wen;
  logic               r_fifo_full = 1'b0;
  logic [1:0]         b_fifo_wdata;
  logic               b_fifo_wen;
  logic               b_fifo_full = 1'b0;

  sram_burst_controller #(
    .AXI_ADDR_WIDTH(AW), .SRAM_ADDR_WIDTH(SAW), .SRAM_DATA_WIDTH(DW),
    .READ_LATENCY(RL), .LEN_WIDTH(LW)
  ) dut (
    .sram_clk(clk), .sram_rst(rst),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
    .sram_we(sram_we), .sram_en(sram_en),
    .aw_fifo_rdata(aw_fifo_rdata), .aw_fifo_ren(aw_fifo_ren), .aw_fifo_empty(aw_fifo_empty),
    .w_fifo_rdata(w_fifo_rdata), .w_fifo_ren(w_fifo_ren), .w_fifo_empty(w_fifo_empty),
    .ar_fifo_rdata(ar_fifo_rdata), .ar_fifo_ren(ar_fifo_ren), .ar_fifo_empty(ar_fifo_empty),
    .r_fifo_wdata(r_fifo_wdata), .r_fifo_wen(r_fifo_wen), .r_fifo_full(r_fifo_full),
    .b_fifo_wdata(b_fifo_wdata), .b_fifo_wen(b_fifo_wen), .b_fifo_full(b_fifo_full)
  );

  // ---------------- scoreboard state ----------------
  logic [DW+2:0]    exp_r_q[$];
  logic [1:0]       exp_b_q[$];
  logic [SW-1:0]    exp_s_q[$];
  logic [LW+AW-1:0] ar_q[$];
  logic [LW+AW-1:0] aw_q[$];
  logic [DW+BY-1:0] w_q[$];
  logic [7:0]       grant_q[$];

  logic [DW-1:0] sram_mem [65536];
  logic [DW-1:0] ref_mem  [65536];
  logic [DW-1:0] rd_pipe  [RL];
  logic [DW-1:0] rd_next = '0;
  logic          rd_next_v = 1'b0;

  logic r_full_req = 1'b0;
  logic sram_chk_en = 1'b1;
  logic bp_win = 1'b0;
  int   rd_out = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Mid-cycle monitor: FIFO handshakes, scoreboard pops, SRAM array access
  always @(negedge clk) begin
    rd_next_v = 1'b0;
    if (ar_fifo_ren) begin
      check("ar_pop_nonempty", ar_fifo_empty, 0);
      if (ar_q.size() != 0) void'(ar_q.pop_front());
      grant_q.push_back(8'h52);
    end
    if (aw_fifo_ren) begin
      check("aw_pop_nonempty", aw_fifo_empty, 0);
      if (aw_q.size() != 0) void'(aw_q.pop_front());
      grant_q.push_back(8'h57);
    end
    if (w_fifo_ren) begin
      check("w_pop_nonempty", w_fifo_empty, 0);
      if (w_q.size() != 0) void'(w_q.pop_front());
    end
    if (r_fifo_wen) begin
      check("r_push_not_full", r_fifo_full, 0);
      if (exp_r_q.size() == 0) check("r_extra", r_fifo_wen, 0);
      else check("r_beat", r_fifo_wdata, exp_r_q.pop_front());
    end
    if (b_fifo_wen) begin
      check("b_push_not_full", b_fifo_full, 0);
      if (exp_b_q.size() == 0) check("b_extra", b_fifo_wen, 0);
      else check("bresp", b_fifo_wdata, exp_b_q.pop_front());
    end
    if (sram_en && sram_chk_en) begin
      if (exp_s_q.size() == 0) check("sram_extra", sram_en, 0);
      else check("sram_access", {sram_addr, sram_we, sram_din}, exp_s_q.pop_front());
    end
    if (sram_en) begin
      rd_next   = sram_mem[sram_addr];
      rd_next_v = (sram_we == '0);
      for (int b = 0; b < BY; b++)
        if (sram_we[b]) sram_mem[sram_addr][8*b +: 8] = sram_din[8*b +: 8];
    end
    if (rst) rd_out = 0;
    else begin
      if (sram_en && sram_we == '0 && sram_din == '0) rd_out++;
      if (r_fifo_wen && r_fifo_wdata[DW+1:DW] == 2'b00) rd_out--;
      if (bp_win) check("rd_outstanding_bound", rd_out <= RL + 1, 1);
    end
  end

  // Edge-side model updates: SRAM latency pipe and FIFO head/flag outputs
  always @(posedge clk) begin
    rd_pipe[0] <= rd_next_v ? rd_next : 32'hBAD0BAD0;
    for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    ar_fifo_empty <= (ar_q.size() == 0);
    ar_fifo_rdata <= (ar_q.size() != 0) ? ar_q[0] : '0;
    aw_fifo_empty <= (aw_q.size() == 0);
    aw_fifo_rdata <= (aw_q.size() != 0) ? aw_q[0] : '0;
    w_fifo_empty  <= (w_q.size() == 0);
    w_fifo_rdata  <= (w_q.size() != 0) ? w_q[0] : '0;
    r_fifo_full   <= r_full_req;
  end
  assign sram_dout = rd_pipe[RL-1];

  // ---------------- driver tasks ----------------
  task automatic do_read(input logic [AW-1:0] baddr, input int len);
    logic           oor;
    logic [SAW-1:0] w;
    logic           last;
    oor = |baddr[AW-1:SAW+2];
    w   = baddr[SAW+1:2];
    ar_q.push_back({LW'(len), baddr});
    for (int i = 0; i <= len; i++) begin
      last = (i == len);
      if (oor) exp_r_q.push_back({last, 2'b10, 32'h0});
      else begin
        exp_s_q.push_back({w, 4'h0, 32'h0});
        exp_r_q.push_back({last, 2'b00, ref_mem[w]});
      end
      w = w + 1'b1;
    end
  endtask

  task automatic do_write(input logic [AW-1:0] baddr, input int len,
                          input logic [4*DW-1:0] data, input logic [4*BY-1:0] strb);
    logic           oor;
    logic [SAW-1:0] w;
    logic [DW-1:0]  d;
    logic [BY-1:0]  s;
    oor = |baddr[AW-1:SAW+2];
    w   = baddr[SAW+1:2];
    aw_q.push_back({LW'(len), baddr});
    for (int i = 0; i <= len; i++) begin
      d = data[i*DW +: DW];
      s = strb[i*BY +: BY];
      w_q.push_back({s, d});
      if (!oor) begin
        exp_s_q.push_back({w, s, d});
        for (int b = 0; b < BY; b++)
          if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
      end
      w = w + 1'b1;
    end
    exp_b_q.push_back(oor ? 2'b10 : 2'b00);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_r_q.size() != 0 || exp_b_q.size() != 0 || exp_s_q.size() != 0 ||
            ar_q.size() != 0 || aw_q.size() != 0 || w_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_done"}, n < budget, 1);
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_en"}, sram_en, 0);
    check({tag, "_we"}, sram_we, 0);
    check({tag, "_addr"}, sram_addr, 0);
    check({tag, "_din"}, sram_din, 0);
    check({tag, "_ar_ren"}, ar_fifo_ren, 0);
    check({tag, "_aw_ren"}, aw_fifo_ren, 0);
    check({tag, "_w_ren"}, w_fifo_ren, 0);
    check({tag, "_r_wen"}, r_fifo_wen, 0);
    check({tag, "_b_wen"}, b_fifo_wen, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] exp_order [8];
    for (int a = 0; a < 65536; a++) begin
      sram_mem[a] = {16'(a) ^ 16'h5A5A, 16'(a)};
      ref_mem[a]  = {16'(a) ^ 16'h5A5A, 16'(a)};
    end
    sram_mem[4] = 32'hDEADBEEF;
    ref_mem[4]  = 32'hDEADBEEF;
    for (int k = 0; k < RL; k++) rd_pipe[k] = '0;

    // Reset with a read already waiting: nothing may move while reset is held.
    rst = 1'b1;
    do_read(32'h0000_0010, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    wait_done("single_read", 50);

    // Write burst words 8..11, then read them back through the merged model
    do_write(32'h0000_0020, 3, {32'h44, 32'h33, 32'h22, 32'h11}, {4'h0, 4'hF, 4'h3, 4'hF});
    wait_done("write_burst", 60);
    do_read(32'h0000_0020, 3);
    wait_done("readback", 60);

    // 8-beat read with R FIFO full for 5 cycles mid-burst
    do_read(32'h0000_0100, 7);
    repeat (4) @(posedge clk);
    #1;
    bp_win = 1'b1;
    r_full_req = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    r_full_req = 1'b0;
    wait_done("backpressure", 100);
    bp_win = 1'b0;

    // Out-of-range read and write: SLVERR, no SRAM traffic
    do_read(32'h0004_0000, 1);
    do_write(32'h0004_0000, 1, {32'h0, 32'h0, 32'hAAAA_AAAA, 32'hBBBB_BBBB}, 16'hFFFF);
    wait_done("oor", 80);

    // Word address wrap 0xFFFF -> 0x0000
    do_read(32'h0003_FFFC, 1);
    wait_done("wrap_read", 60);
    do_write(32'h0003_FFFC, 1, {32'h0, 32'h0, 32'h0000_CAFE, 32'h0000_F00D}, 16'h00FF);
    wait_done("wrap_write", 60);
    do_read(32'h0003_FFFC, 1);
    wait_done("wrap_readback", 60);

    // Alternation from a clean pointer: reads and writes all pending together
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    grant_q.delete();
    for (int i = 0; i < 4; i++) begin
      do_read(32'h0000_0400 + 32'(16 * i), 0);
      do_write(32'h0000_0800 + 32'(16 * i), 0,
               {96'h0, 32'(32'h1000_0000 + i)}, {12'h0, 4'hF});
    end
    wait_done("alternate", 200);
    for (int i = 0; i < 8; i++) exp_order[i] = (i % 2 == 0) ? 8'h52 : 8'h57;
    check("grant_count", grant_q.size(), 8);
    for (int i = 0; i < 8; i++) check("grant_order", grant_q[i], exp_order[i]);

    // Reset in the middle of a backpressured read burst
    r_full_req = 1'b1;
    sram_chk_en = 1'b0;
    @(posedge clk); #1;
    ar_q.push_back({4'd7, 32'h0000_1000});
    repeat (6) @(posedge clk);
    #1;
    check("rst_burst_started", ar_q.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    r_full_req = 1'b0;
    sram_chk_en = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    do_read(32'h0000_0010, 0);
    wait_done("after_reset", 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
